seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 112 +++++++++++
 tb/tb_seq_multiplier.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed/unsigned per operation, WIDTH-parametrised.
// Optional early termination on zero multiplier remainder: SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t          state;
    state_t          next;

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    acc_add;
    logic [WIDTH-1:0] mplier_nx;
    logic [CW-1:0]    cnt_nx;
    logic             last;

    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    always_comb begin
        mag_a     = (signed_mode && ina[WIDTH-1]) ? -ina : ina;
        mag_b     = (signed_mode && inb[WIDTH-1]) ? -inb : inb;
        acc_add   = mplier[0] ? acc + mcand : acc;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt - CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        last      = (cnt_nx == '0) || (mplier_nx == '0);
`else
        last      = (cnt_nx == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (start) next = RUN;
            RUN:  if (last) next = FIX;
            FIX:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        cnt    <= CW'(WIDTH);
                        neg    <= signed_mode & (ina[WIDTH-1] ^ inb[WIDTH-1]);
                    end
                end
                RUN: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nx;
                    cnt    <= cnt_nx;
                end
                FIX: begin
                    out  <= neg ? -acc : acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=8 and WIDTH=16 instances).
// Expected latencies follow SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_multiplier;

    logic        clk;
    logic        rst;

    logic        start;
    logic        signed_mode;
    logic [7:0]  ina;
    logic [7:0]  inb;
    logic        busy;
    logic        done;
    logic [15:0] out;

    logic        start16;
    logic        signed_mode16;
    logic [15:0] ina16;
    logic [15:0] inb16;
    logic        busy16;
    logic        done16;
    logic [31:0] out16;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start),
        .signed_mode(signed_mode), .ina(ina), .inb(inb),
        .busy(busy), .done(done), .out(out)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16),
        .signed_mode(signed_mode16), .ina(ina16), .inb(inb16),
        .busy(busy16), .done(done16), .out(out16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges from the accepting edge E0 until done is seen.
    function automatic int exp_lat8(input logic [7:0] b, input logic sm);
        logic [7:0] m;
        int r;
        m = (sm && b[7]) ? -b : b;
        r = 1;
        for (int i = 0; i < 8; i++) if (m[i]) r = i + 1;
`ifndef SEQ_MULT_EARLY_TERM_EN
        r = 8;
`endif
        return r + 1;
    endfunction

    // lat=0 means done never came within the budget.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic sm, output logic [15:0] p,
                         output int lat, output int bcnt,
                         output logic bdone);
        p = '0; lat = 0; bcnt = 0; bdone = 1'b1;
        @(negedge clk);
        ina = a; inb = b; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ina = ~a; inb = ~b; signed_mode = ~sm;
        if (busy) bcnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k; p = out; bdone = busy;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                           input logic sm, output logic [31:0] p,
                           output int lat);
        p = '0; lat = 0;
        @(negedge clk);
        ina16 = a; inb16 = b; signed_mode16 = sm; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                lat = k; p = out16;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b out=%h want 0 0 0000",
                     busy, done, out);
        end
        checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || out16 !== 32'h0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b out=%h want 0 0 0",
                     busy16, done16, out16);
        end
        rst = 1'b0;
    endtask

    task automatic test_products();
        logic [7:0]  va [10] = '{8'd255, 8'h80, 8'hFD, 8'h7F, 8'd200,
                                 8'd5, 8'd3, 8'hFF, 8'h80, 8'h80};
        logic [7:0]  vb [10] = '{8'd255, 8'h80, 8'h07, 8'h80, 8'd1,
                                 8'd0, 8'h80, 8'hFF, 8'h7F, 8'h80};
        logic        vs [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] vp [10] = '{16'hFE01, 16'h4000, 16'hFFEB, 16'hC080,
                                 16'h00C8, 16'h0000, 16'h0180, 16'h0001,
                                 16'hC080, 16'h4000};
        logic [15:0] p;
        int lat, bcnt, el;
        logic bd;
        for (int i = 0; i < 10; i++) begin
            do_op(va[i], vb[i], vs[i], p, lat, bcnt, bd);
            el = exp_lat8(vb[i], vs[i]);
            checks++;
            if (p !== vp[i]) begin
                errors++;
                $display("FAIL product[%0d]: out=%h want %h", i, p, vp[i]);
            end
            checks++;
            if (lat != el) begin
                errors++;
                $display("FAIL latency[%0d]: %0d edges want %0d", i, lat, el);
            end
            checks++;
            if (bcnt != el || bd !== 1'b0) begin
                errors++;
                $display("FAIL busy[%0d]: high %0d cycles, at done %b want %0d, 0",
                         i, bcnt, bd, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        logic gap;
        logic [15:0] p1;
        k1 = 0; k2 = 0; gap = 1'b0; p1 = '0;
        @(negedge clk);
        ina = 8'd3; inb = 8'd5; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        ina = 8'd10; inb = 8'd10;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                k1 = k; p1 = out;
                break;
            end
            if (!busy) gap = 1'b1;
        end
        checks++;
        if (p1 !== 16'd15 || k1 != exp_lat8(8'd5, 1'b0) || gap) begin
            errors++;
            $display("FAIL b2b_first: out=%0d lat=%0d idle=%b want 15 %0d 0",
                     p1, k1, gap, exp_lat8(8'd5, 1'b0));
        end
        @(posedge clk); #1;
        start = 1'b0; ina = 8'd77; inb = 8'd99;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b after done cycle want 1", busy);
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                k2 = k;
                break;
            end
        end
        checks++;
        if (out !== 16'd100 || k2 != exp_lat8(8'd10, 1'b0)) begin
            errors++;
            $display("FAIL b2b_second: out=%0d lat=%0d want 100 %0d",
                     out, k2, exp_lat8(8'd10, 1'b0));
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        logic [15:0] p;
        int lat, bcnt;
        logic bd;
        seen = 1'b0;
        @(negedge clk);
        ina = 8'd9; inb = 8'hC9; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out !== 16'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b out=%h done=%b want 0 0000 0",
                     busy, out, done);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: activity=%b after reset want 0", seen);
        end
        do_op(8'd6, 8'd7, 1'b0, p, lat, bcnt, bd);
        checks++;
        if (p !== 16'd42 || lat != exp_lat8(8'd7, 1'b0)) begin
            errors++;
            $display("FAIL abort_restart: out=%0d lat=%0d want 42 %0d",
                     p, lat, exp_lat8(8'd7, 1'b0));
        end
    endtask

    task automatic test_sweep16();
        logic [15:0] a, b;
        logic sm;
        logic [31:0] ea, eb, ep, p;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            sm = 1'($urandom_range(0, 1));
            if (i == 0) begin a = 16'h8000; b = 16'h8000; sm = 1'b1; end
            if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; sm = 1'b0; end
            if (i == 2) begin a = 16'h7FFF; b = 16'h8000; sm = 1'b1; end
            ea = sm ? {{16{a[15]}}, a} : {16'h0, a};
            eb = sm ? {{16{b[15]}}, b} : {16'h0, b};
            ep = ea * eb;
            do_op16(a, b, sm, p, lat);
            checks++;
            if (lat == 0 || p !== ep) begin
                errors++;
                $display("FAIL sweep16[%0d]: %h*%h sm=%b out=%h lat=%0d want %h",
                         i, a, b, sm, p, lat, ep);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; signed_mode = 1'b0; ina = '0; inb = '0;
        start16 = 1'b0; signed_mode16 = 1'b0; ina16 = '0; inb16 = '0;
        test_reset();
        test_products();
        test_back_to_back();
        test_reset_abort();
        test_sweep16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
